// File: rtl/pmem_rd_streamer_pkg.sv
// Shared definitions for the pmem-facing blocks: default widths, the read
// streamer state encoding and a small occupancy helper.
package pmem_rd_streamer_pkg;

  localparam int unsigned PMEM_ADDR_W = 14;
  localparam int unsigned PMEM_DATA_W = 128;
  localparam int unsigned PMEM_LEN_W  = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_e;

  // Words already committed downstream of the memory port: buffered plus in flight.
  function automatic logic [1:0] occupancy(input logic [1:0] fifo_count,
                                           input logic       inflight);
    return fifo_count + {1'b0, inflight};
  endfunction

endpackage

// File: rtl/pmem_rd_streamer_fifo.sv
// stream_fifo2: 2-entry first-word-fall-through FIFO; an empty FIFO passes
// the pushed word straight to its output in the same cycle.
module stream_fifo2 #(
  parameter int unsigned WIDTH = 128
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             empty, pop, push_store, pop_head;

  always_comb begin
    empty     = (count_q == 2'd0);
    out_valid = !empty || in_valid;
    out_data  = empty ? in_data : mem_q[rd_ptr_q];
    pop       = out_valid && out_ready;
    // A push into an empty FIFO that is popped the same cycle never gets stored.
    push_store = in_valid && !(empty && pop) && (count_q != 2'd2);
    pop_head   = pop && !empty;

    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (push_store) begin
      mem_d[wr_ptr_q] = in_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop_head) rd_ptr_d = ~rd_ptr_q;
    count_d = count_q + 2'(push_store) - 2'(pop_head);
    count   = count_q;
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (reset) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/pmem_rd_streamer.sv
// Streams a burst of consecutive pmem words to a ready/valid sink, keeping at
// most two words outstanding between the memory port and the sink.
module pmem_rd_streamer
  import pmem_rd_streamer_pkg::*;
#(
  parameter int unsigned ADDR_W = PMEM_ADDR_W,
  parameter int unsigned DATA_W = PMEM_DATA_W,
  parameter int unsigned LEN_W  = PMEM_LEN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              mem_cen,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_a,
  input  logic [DATA_W-1:0] mem_q,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  rd_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  issue_left_q, issue_left_d;
  logic [LEN_W-1:0]  out_left_q, out_left_d;
  logic              inflight_q, inflight_d;
  logic              zero_done_q, zero_done_d;

  logic              issue, xfer, last_xfer;
  logic [1:0]        fifo_count;
  logic              fifo_valid;
  logic [DATA_W-1:0] fifo_data;

  always_comb begin
    issue = (state_q == ST_RUN) && (issue_left_q != '0)
            && (occupancy(fifo_count, inflight_q) < 2'd2);
    xfer      = fifo_valid && out_ready;
    last_xfer = (state_q == ST_DRAIN) && xfer && (out_left_q == LEN_W'(1));

    state_d      = state_q;
    addr_d       = addr_q;
    issue_left_d = issue_left_q;
    out_left_d   = out_left_q;
    inflight_d   = issue;
    zero_done_d  = 1'b0;

    if (xfer) out_left_d = out_left_q - LEN_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (len != '0) begin
            state_d      = ST_RUN;
            addr_d       = base_addr;
            issue_left_d = len;
            out_left_d   = len;
          end else begin
            zero_done_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (issue) begin
          addr_d       = addr_q + ADDR_W'(1);
          issue_left_d = issue_left_q - LEN_W'(1);
          if (issue_left_q == LEN_W'(1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (last_xfer) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy      = (state_q != ST_IDLE);
    done      = zero_done_q || last_xfer;
    mem_cen   = !issue;
    mem_wen   = 1'b1;
    mem_a     = addr_q;
    out_valid = fifo_valid;
    out_data  = fifo_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      issue_left_q <= '0;
      out_left_q   <= '0;
      inflight_q   <= 1'b0;
      zero_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      issue_left_q <= issue_left_d;
      out_left_q   <= out_left_d;
      inflight_q   <= inflight_d;
      zero_done_q  <= zero_done_d;
    end
  end

  stream_fifo2 #(.WIDTH(DATA_W)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (inflight_q),
    .in_data   (mem_q),
    .out_ready (out_ready),
    .out_valid (fifo_valid),
    .out_data  (fifo_data),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_pmem_rd_streamer.sv
// Directed bench for pmem_rd_streamer against a memory holding mem[i] = i.
module tb_pmem_rd_streamer;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [13:0]  base_addr;
  logic [14:0]  len;
  logic         busy, done, mem_cen, mem_wen, out_valid, out_ready;
  logic [13:0]  mem_a;
  logic [127:0] mem_q, out_data;

  int checks = 0;
  int errors = 0;
  logic [127:0] got_w [0:31];
  int n_got;

  always #5 clk = ~clk;

  always @(posedge clk) if (!mem_cen) mem_q <= 128'(mem_a);

  pmem_rd_streamer #(.ADDR_W(14), .DATA_W(128), .LEN_W(15)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .mem_cen   (mem_cen),
    .mem_wen   (mem_wen),
    .mem_a     (mem_a),
    .mem_q     (mem_q),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 128'(busy), 128'd0);
    check({tag, "_done"}, 128'(done), 128'd0);
    check({tag, "_cen"}, 128'(mem_cen), 128'd1);
    check({tag, "_wen"}, 128'(mem_wen), 128'd1);
    check({tag, "_a"}, 128'(mem_a), 128'd0);
    check({tag, "_valid"}, 128'(out_valid), 128'd0);
  endtask

  // mode 0: out_ready held high; mode 1: out_ready pattern 1,0,0,1 repeating.
  // mid_start pulses a second start (base 900, len 3) in cycle 3.
  task automatic run_burst(input string tag, input logic [13:0] base, input logic [14:0] blen,
                           input int mode, input bit mid_start,
                           output int first_cyc, output int done_cyc);
    int issued = 0, xfers = 0, viol = 0, addr_err = 0, wen_err = 0, done_n = 0, last_x = -1;
    logic [13:0] ea;
    first_cyc = -1;
    done_cyc  = -1;
    n_got     = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      start     = (c == 0) || (mid_start && c == 3);
      base_addr = (c == 0) ? base : 14'd900;
      len       = (c == 0) ? blen : 15'd3;
      out_ready = (mode == 0) ? 1'b1 : ((c % 4 == 0) || (c % 4 == 3));
      #1;
      if (!mem_cen) begin
        if (issued - xfers >= 2) viol++;
        ea = base + 14'(issued);
        if (mem_a !== ea) addr_err++;
        issued++;
      end
      if (mem_wen !== 1'b1) wen_err++;
      if (out_valid && out_ready) begin
        if (n_got < 32) got_w[n_got] = out_data;
        n_got++;
        if (first_cyc < 0) first_cyc = c;
        last_x = c;
        xfers++;
      end
      if (done) begin
        done_n++;
        done_cyc = c;
      end
      if (done_n > 0 && c >= done_cyc + 3) break;
    end
    start = 1'b0;
    if (done_n == 0) check({tag, "_timeout"}, 128'd1, 128'd0);
    check({tag, "_nwords"}, 128'(n_got), 128'(blen));
    check({tag, "_ndone"}, 128'(done_n), 128'd1);
    check({tag, "_done_at_last"}, 128'(done_cyc), 128'(last_x));
    check({tag, "_outstanding"}, 128'(viol), 128'd0);
    check({tag, "_addr"}, 128'(addr_err), 128'd0);
    check({tag, "_wen"}, 128'(wen_err), 128'd0);
    check({tag, "_idle_after"}, 128'(busy), 128'd0);
    for (int k = 0; k < n_got && k < 32; k++) begin
      ea = base + 14'(k);
      check($sformatf("%s_word%0d", tag, k), got_w[k], 128'(ea));
    end
  endtask

  initial begin
    int fc, dc;
    reset = 1'b1; start = 1'b0; base_addr = '0; len = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_idle_outputs("reset");
    @(negedge clk);
    reset = 1'b0;

    run_burst("b0l4", 14'd0, 15'd4, 0, 1'b0, fc, dc);
    check("b0l4_first_valid_cycle", 128'(fc), 128'd2);
    check("b0l4_done_cycle", 128'(dc), 128'd5);

    run_burst("wrap", 14'd16382, 15'd4, 0, 1'b0, fc, dc);
    check("wrap_w1", got_w[1], 128'd16383);
    check("wrap_w2", got_w[2], 128'd0);
    check("wrap_w3", got_w[3], 128'd1);

    run_burst("toggle", 14'd200, 15'd8, 1, 1'b0, fc, dc);
    run_burst("midstart", 14'd40, 15'd8, 0, 1'b1, fc, dc);
    check("midstart_w7", got_w[7], 128'd47);

    // Zero-length start: a lone done pulse one cycle later, no memory traffic.
    begin
      int cen_low = 0, vld = 0;
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        start = (c == 0); base_addr = 14'd5; len = 15'd0; out_ready = 1'b1;
        #1;
        if (!mem_cen) cen_low++;
        if (out_valid) vld++;
        if (c == 0) check("zero_done_c0", 128'(done), 128'd0);
        if (c == 1) check("zero_done_c1", 128'(done), 128'd1);
        if (c == 2) check("zero_done_c2", 128'(done), 128'd0);
        if (c == 1) check("zero_busy_c1", 128'(busy), 128'd0);
      end
      start = 1'b0;
      check("zero_cen_low", 128'(cen_low), 128'd0);
      check("zero_valid", 128'(vld), 128'd0);
    end

    // Reset three cycles into a 16-word burst.
    begin
      int dn = 0;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        start = (c == 0); base_addr = 14'd100; len = 15'd16; out_ready = 1'b1;
        reset = (c == 3);
        #1;
        if (c == 2) check("rst_busy_before", 128'(busy), 128'd1);
      end
      start = 1'b0;
      @(negedge clk);
      #1;
      check_idle_outputs("rst_mid");
      reset = 1'b0;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        #1;
        if (done || out_valid || busy || !mem_cen) dn++;
      end
      check("rst_quiet_after", 128'(dn), 128'd0);
      run_burst("post_rst", 14'd7, 15'd2, 0, 1'b0, fc, dc);
      check("post_rst_first", 128'(fc), 128'd2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
